mem_data_interface: RTL and testbench
=====================================

// Module: mem_data_interface
// PURPOSE
//   Memory-side source for the datapath bus: holds MAR and MDR and runs single-word
//   read/write transactions to the unified memory over a req/ack handshake.
//   mdr_out drives the MDR input of the bus multiplexer. MAR and MDR load from BusMuxOut.
//   Reads capture memory data into MDR. Writes store MDR at MAR.
// PARAMETERS
//   ADDR_W   9    memory word-address width; MAR = BusMuxOut[ADDR_W-1:0]
//   TIMEOUT  15   max cycles mem_req may stay high without mem_ack before abort (>=1)
// PORTS
//   clk        in   1       rising-edge clock
//   clr        in   1       asynchronous, active-high reset
//   BusMuxOut  in   32      datapath bus value
//   MARin      in   1       load MAR from BusMuxOut[ADDR_W-1:0]
//   MDRin      in   1       load MDR from BusMuxOut
//   rd_start   in   1       start read of mem[MAR] into MDR (sampled in IDLE only)
//   wr_start   in   1       start write of MDR to mem[MAR] (sampled in IDLE only)
//   mem_rdata  in   32      memory read data, valid when mem_ack=1 on a read
//   mem_ack    in   1       memory completion strobe
//   mem_addr   out  ADDR_W  = MAR
//   mem_wdata  out  32      = MDR
//   mem_req    out  1       transaction request (registered)
//   mem_we     out  1       1 = write, 0 = read (registered; meaningful while mem_req=1)
//   mdr_out    out  32      = MDR, to bus mux MDR input
//   busy       out  1       high in WAIT and DONE
//   done       out  1       one-cycle completion pulse
//   err        out  1       one-cycle pulse with done when the transaction timed out
// BEHAVIOUR
//   Reset: MAR=0, MDR=0, state=IDLE, mem_req=mem_we=busy=done=err=0, wait_cnt=0. Async reset
//     mid-transaction abandons it: mem_req drops immediately; no done, no MDR update.
//   FSM: IDLE -> WAIT -> DONE -> IDLE. All outputs registered.
//   IDLE: MARin/MDRin load on the edge. rd_start or wr_start moves to WAIT, with
//     mem_req=1 and mem_we=wr_start&~rd_start from the next cycle. Both starts high
//     means read wins. A start in the same cycle as MARin/MDRin uses the newly loaded value.
//   WAIT: MAR and MDR frozen (MARin, MDRin, starts ignored). wait_cnt increments each cycle.
//     mem_ack=1: a read loads MDR<=mem_rdata. Next state DONE, err=0.
//     No ack and wait_cnt==TIMEOUT-1, i.e. mem_req has been high TIMEOUT cycles:
//       next state DONE with err=1. MDR unchanged; memory is not written by this block afterwards.
//     Ack on the timeout cycle: ack wins, err=0.
//   DONE: mem_req=0, done=1 (err as set) for exactly one cycle, then IDLE. Inputs ignored.
//   Latency: start at edge N -> mem_req high after N. With ack sampled at edge N+k,
//     done is high after N+k and MDR holds new data after N+k. New start is accepted after N+k+1.
//   mem_ack while mem_req=0 is ignored.
//   wait_cnt width $clog2(TIMEOUT+1); cleared on entering WAIT; no wrap possible.
// TESTING
//   1 Reset: assert clr mid-cycle -> all outputs 0 asynchronously, MAR=0, MDR=0.
//   2 Bus load/read: MARin w/ bus=0x0000_0085 -> mem_addr=0x085. rd_start, ack after 3 cycles
//     with rdata=0xDEAD_BEEF -> MDR=mdr_out=0xDEADBEEF, done 1 cycle, err=0, busy low after.
//   3 Write: MDRin bus=0x1234_5678 + wr_start same cycle -> mem_we=1,
//     mem_wdata=0x12345678 for the whole request. MDRin=0xFFFF_FFFF during WAIT is ignored.
//   4 Timeout: rd_start, no ack (TIMEOUT=15) -> mem_req high exactly 15 cycles, then
//     done=err=1 for one cycle. MDR keeps its prior value. Repeat with ack on the 15th cycle -> err=0.
//   5 Contention: rd_start&wr_start together -> read (mem_we=0). Stray mem_ack in IDLE
//     -> no effect. rd_start during DONE -> ignored.
//   6 Reset mid-WAIT: clr while mem_req=1 -> mem_req=0 at once, no done; next read completes normally.

Source files
------------

// File: rtl/mem_data_interface.sv
// Memory-side MAR/MDR holder that runs single-word read/write transactions
// over a req/ack handshake, with a bounded wait and a timeout abort.
module mem_data_interface #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              rd_start,
    input  logic              wr_start,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mdr_out,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_mar;
    logic [31:0]       r_mdr;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_req;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_mar      <= '0;
            r_mdr      <= '0;
            r_wait_cnt <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (MARin) r_mar <= BusMuxOut[ADDR_W-1:0];
                    if (MDRin) r_mdr <= BusMuxOut;
                    if (rd_start || wr_start) begin
                        r_state    <= ST_WAIT;
                        r_req      <= 1'b1;
                        r_we       <= wr_start & ~rd_start;
                        r_busy     <= 1'b1;
                        r_wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    // An ack arriving on the last allowed cycle still counts as success.
                    if (mem_ack) begin
                        if (!r_we) r_mdr <= mem_rdata;
                        r_state <= ST_DONE;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                    end else if (r_wait_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = r_mar;
    assign mem_wdata = r_mdr;
    assign mdr_out   = r_mdr;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
endmodule

// File: tb/tb_mem_data_interface.sv
// Randomized bench for mem_data_interface: a transaction-level model predicts every
// output each cycle, and directed scenarios pin the model with literal expectations.
module tb_mem_data_interface;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              clr = 1'b1;
    logic [31:0]       BusMuxOut = '0;
    logic              MARin = 1'b0, MDRin = 1'b0, rd_start = 1'b0, wr_start = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mdr_out;
    logic              mem_req, mem_we, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_data_interface #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
        .rd_start(rd_start), .wr_start(wr_start), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mdr_out(mdr_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request is "in flight" for a number of cycles; it ends on the first ack
    // or after TIMEOUT cycles, followed by exactly one done cycle.
    logic [ADDR_W-1:0] m_mar;
    logic [31:0]       m_mdr;
    bit                m_req, m_we, m_busy, m_done, m_err;
    int                m_age;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_mar = '0; m_mdr = '0; m_req = 0; m_we = 0;
            m_busy = 0; m_done = 0; m_err = 0; m_age = 0;
        end else if (m_done) begin
            m_done = 0; m_err = 0; m_busy = 0;
        end else if (m_req) begin
            m_age++;
            if (mem_ack) begin
                if (!m_we) m_mdr = mem_rdata;
                m_req = 0; m_we = 0; m_done = 1; m_err = 0;
            end else if (m_age == TIMEOUT) begin
                m_req = 0; m_we = 0; m_done = 1; m_err = 1;
            end
        end else begin
            if (MARin) m_mar = BusMuxOut[ADDR_W-1:0];
            if (MDRin) m_mdr = BusMuxOut;
            if (rd_start || wr_start) begin
                m_req = 1; m_we = wr_start && !rd_start; m_busy = 1; m_age = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!clr) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_mar));
            chk("mdr_out", mdr_out, m_mdr);
            chk("mem_wdata", mem_wdata, m_mdr);
            chk("mem_req", 32'(mem_req), 32'(m_req));
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
        end
    end

    task automatic idle_noise(input int n);
        for (int k = 0; k < n; k++) begin
            BusMuxOut = $urandom;
            MARin     = 1'($urandom_range(0, 1));
            MDRin     = 1'($urandom_range(0, 1));
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clk);
        end
        MARin = 0; MDRin = 0; mem_ack = 0;
    endtask

    // Issue a start (caller may pre-set bus loads), ack at request cycle ack_at.
    task automatic run(input bit rd, input bit wr, input int ack_at, input logic [31:0] rdata,
                       output int req_cycles, output bit saw_err, output bit we_seen);
        bit saw_done;
        req_cycles = 0; saw_err = 0; we_seen = 0; saw_done = 0;
        rd_start = rd; wr_start = wr;
        @(negedge clk);
        rd_start = 0; wr_start = 0; MARin = 0; MDRin = 0; mem_ack = 0;
        for (int i = 1; i <= 40; i++) begin
            if (mem_req) begin
                req_cycles++;
                we_seen = mem_we;
            end
            if (done) begin
                saw_done = 1;
                saw_err  = err;
                break;
            end
            mem_ack   = (i == ack_at);
            mem_rdata = (i == ack_at) ? rdata : $urandom;
            BusMuxOut = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom;
            MDRin     = 1'($urandom_range(0, 1));
            MARin     = 1'($urandom_range(0, 1));
            rd_start  = 1'($urandom_range(0, 1));
            wr_start  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("done_within_bound", 32'(saw_done), 32'd1);
        // A start presented while DONE is showing must be ignored.
        mem_ack = 0; MARin = 0; MDRin = 0; rd_start = 1; wr_start = 0;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        rd_start = 0;
    endtask

    int          rc;
    bit          e, w;
    logic [31:0] prior;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk); @(negedge clk);
        clr = 0;
        chk("reset_req", 32'(mem_req), 32'd0);
        chk("reset_mdr", mdr_out, 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);

        // Bus load then read with ack after 3 request cycles.
        BusMuxOut = 32'h0000_0085; MARin = 1;
        @(negedge clk);
        MARin = 0;
        chk("mar_load", 32'(mem_addr), 32'h085);
        run(1, 0, 3, 32'hDEAD_BEEF, rc, e, w);
        chk("read_mdr", mdr_out, 32'hDEAD_BEEF);
        chk("read_req_cycles", 32'(rc), 32'd3);
        chk("read_err", 32'(e), 32'd0);
        chk("read_we", 32'(w), 32'd0);

        // Write with MDR loaded in the same cycle as the start.
        BusMuxOut = 32'h1234_5678; MDRin = 1;
        run(0, 1, 4, 32'h0, rc, e, w);
        chk("write_we", 32'(w), 32'd1);
        chk("write_wdata", mem_wdata, 32'h1234_5678);

        // Timeout: no ack, then ack exactly on the last allowed cycle.
        prior = mdr_out;
        run(1, 0, 99, 32'hAAAA_5555, rc, e, w);
        chk("timeout_req_cycles", 32'(rc), 32'd15);
        chk("timeout_err", 32'(e), 32'd1);
        chk("timeout_mdr_kept", mdr_out, prior);
        run(1, 0, 15, 32'hCAFE_F00D, rc, e, w);
        chk("late_ack_err", 32'(e), 32'd0);
        chk("late_ack_req_cycles", 32'(rc), 32'd15);
        chk("late_ack_mdr", mdr_out, 32'hCAFE_F00D);

        // Contention: read wins; stray acks in idle are ignored.
        idle_noise(4);
        run(1, 1, 2, 32'h0BAD_F00D, rc, e, w);
        chk("both_start_we", 32'(w), 32'd0);
        chk("both_start_mdr", mdr_out, 32'h0BAD_F00D);

        // Reset in the middle of a request.
        rd_start = 1;
        @(negedge clk);
        rd_start = 0;
        @(negedge clk); @(negedge clk);
        #2 clr = 1;
        #1;
        chk("clr_req", 32'(mem_req), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_mdr", mdr_out, 32'd0);
        @(negedge clk);
        clr = 0;
        run(1, 0, 2, 32'h5A5A_A5A5, rc, e, w);
        chk("post_clr_mdr", mdr_out, 32'h5A5A_A5A5);
        chk("post_clr_err", 32'(e), 32'd0);

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            idle_noise(int'($urandom_range(0, 3)));
            BusMuxOut = $urandom;
            MARin = 1'($urandom_range(0, 1));
            MDRin = 1'($urandom_range(0, 1));
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | 1'b0,
                int'($urandom_range(1, 20)), $urandom, rc, e, w);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
